axi_pwm_custom_ramp: RTL and testbench

Per-channel slew-rate limiter that sits directly upstream of the 4-channel PWM interface. Its four 12-bit duty outputs drive that interface's data_channel_0..3 inputs. It takes software-written target duties and moves each output toward its target by at most STEP codes per update tick, so LED brightness fades instead of jumping. A single shared add/compare datapath is time-multiplexed across channels by a small sequencer FSM.

---
 rtl/axi_pwm_custom_ramp_if.sv | 33 +++
 rtl/axi_pwm_custom_ramp.sv | 98 +++++++++
 tb/tb_axi_pwm_custom_ramp.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pwm_custom_ramp_if.sv
// axi_pwm_custom_ramp_if: control, target and ramped-duty signals between software side and the ramp limiter
//   master: drives enable, load_now, step, tick_div, target_channel_0..3; observes data_channel_0..3, settled
//   slave : the ramp limiter, the mirror of master
interface axi_pwm_custom_ramp_if #(
    parameter int DATA_WIDTH = 12,
    parameter int DIV_WIDTH  = 16
);
    logic                  enable;
    logic                  load_now;
    logic [DATA_WIDTH-1:0] step;
    logic [DIV_WIDTH-1:0]  tick_div;
    logic [DATA_WIDTH-1:0] target_channel_0;
    logic [DATA_WIDTH-1:0] target_channel_1;
    logic [DATA_WIDTH-1:0] target_channel_2;
    logic [DATA_WIDTH-1:0] target_channel_3;
    logic [DATA_WIDTH-1:0] data_channel_0;
    logic [DATA_WIDTH-1:0] data_channel_1;
    logic [DATA_WIDTH-1:0] data_channel_2;
    logic [DATA_WIDTH-1:0] data_channel_3;
    logic                  settled;

    modport master (
        output enable, load_now, step, tick_div,
        output target_channel_0, target_channel_1, target_channel_2, target_channel_3,
        input  data_channel_0, data_channel_1, data_channel_2, data_channel_3, settled
    );

    modport slave (
        input  enable, load_now, step, tick_div,
        input  target_channel_0, target_channel_1, target_channel_2, target_channel_3,
        output data_channel_0, data_channel_1, data_channel_2, data_channel_3, settled
    );
endinterface

// File: rtl/axi_pwm_custom_ramp.sv
// axi_pwm_custom_ramp: 4-channel slew-rate limiter feeding the PWM interface duty inputs
//   pwm_clk : clock shared with the PWM interface
//   rstn    : asynchronous active-low reset
//   bus     : slave side of axi_pwm_custom_ramp_if (controls and targets in, ramped duties and settled out)
module axi_pwm_custom_ramp #(
    parameter int DATA_WIDTH = 12,
    parameter int DIV_WIDTH  = 16
) (
    input logic                 pwm_clk,
    input logic                 rstn,
    axi_pwm_custom_ramp_if.slave bus
);
    typedef enum logic [2:0] {IDLE, UPD0, UPD1, UPD2, UPD3} state_t;

    state_t                state, state_nxt;
    logic [DIV_WIDTH-1:0]  cnt;
    logic                  tick;
    logic [DATA_WIDTH-1:0] tgt_a [4];
    logic [DATA_WIDTH-1:0] data_q [4];
    logic [1:0]            sel;
    logic [DATA_WIDTH-1:0] cur, tgt, new_val;
    logic [DATA_WIDTH:0]   sum;
    logic signed [DATA_WIDTH:0] diff;
    logic                  all_eq;

    assign tgt_a[0] = bus.target_channel_0;
    assign tgt_a[1] = bus.target_channel_1;
    assign tgt_a[2] = bus.target_channel_2;
    assign tgt_a[3] = bus.target_channel_3;

    assign bus.data_channel_0 = data_q[0];
    assign bus.data_channel_1 = data_q[1];
    assign bus.data_channel_2 = data_q[2];
    assign bus.data_channel_3 = data_q[3];

    assign tick = bus.enable && cnt == bus.tick_div;

    always_ff @(posedge pwm_clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (bus.load_now || !bus.enable || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge pwm_clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Ticks arriving mid-sweep are dropped: only IDLE listens to tick.
    always_comb begin
        state_nxt = state;
        if (bus.load_now || !bus.enable)
            state_nxt = IDLE;
        else
            case (state)
                IDLE:    state_nxt = tick ? UPD0 : IDLE;
                UPD0:    state_nxt = UPD1;
                UPD1:    state_nxt = UPD2;
                UPD2:    state_nxt = UPD3;
                default: state_nxt = IDLE;
            endcase
    end

    // One shared add/compare datapath, steered to the channel of the current UPD state.
    always_comb begin
        sel     = state == UPD1 ? 2'd1 : state == UPD2 ? 2'd2 : state == UPD3 ? 2'd3 : 2'd0;
        cur     = data_q[sel];
        tgt     = tgt_a[sel];
        sum     = {1'b0, cur} + {1'b0, bus.step};
        diff    = signed'({1'b0, cur}) - signed'({1'b0, bus.step});
        new_val = cur < tgt ? (sum > {1'b0, tgt} ? tgt : sum[DATA_WIDTH-1:0]) :
                  cur > tgt ? (diff < signed'({1'b0, tgt}) ? tgt : diff[DATA_WIDTH-1:0]) : cur;
    end

    always_ff @(posedge pwm_clk or negedge rstn) begin
        if (!rstn)
            for (int i = 0; i < 4; i++) data_q[i] <= '0;
        else if (bus.load_now)
            for (int i = 0; i < 4; i++) data_q[i] <= tgt_a[i];
        else if (bus.enable && state != IDLE)
            data_q[sel] <= new_val;
    end

    assign all_eq = data_q[0] == tgt_a[0] && data_q[1] == tgt_a[1] &&
                    data_q[2] == tgt_a[2] && data_q[3] == tgt_a[3];

    always_ff @(posedge pwm_clk or negedge rstn) begin
        if (!rstn)
            bus.settled <= 1'b0;
        else
            bus.settled <= all_eq;
    end
endmodule

// File: tb/tb_axi_pwm_custom_ramp.sv
// tb_axi_pwm_custom_ramp: randomized and directed self-check of axi_pwm_custom_ramp against a behavioural model
module tb_axi_pwm_custom_ramp;
    logic pwm_clk = 1'b0;
    logic rstn    = 1'b1;
    int   errors  = 0;
    int   checks  = 0;

    int   m_d [4];
    int   m_cnt;
    int   m_phase;
    int   m_set;

    axi_pwm_custom_ramp_if #(.DATA_WIDTH(12), .DIV_WIDTH(16)) bus ();

    axi_pwm_custom_ramp #(.DATA_WIDTH(12), .DIV_WIDTH(16)) dut (
        .pwm_clk(pwm_clk),
        .rstn   (rstn),
        .bus    (bus)
    );

    always #5 pwm_clk = ~pwm_clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int ramp(input int c, input int t, input int s);
        if (c < t) return (c + s > t) ? t : c + s;
        if (c > t) return (c - s < t) ? t : c - s;
        return c;
    endfunction

    function automatic int tgt(input int n);
        case (n)
            0: return int'(bus.target_channel_0);
            1: return int'(bus.target_channel_1);
            2: return int'(bus.target_channel_2);
            default: return int'(bus.target_channel_3);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_d[i] = 0;
        m_cnt = 0;
        m_phase = -1;
        m_set = 0;
    endtask

    // m_phase: -1 between sweeps, otherwise the channel updated in the current cycle
    task automatic model_clk();
        int all_eq;
        if (!rstn) begin
            model_reset();
            return;
        end
        all_eq = 1;
        for (int i = 0; i < 4; i++) if (m_d[i] != tgt(i)) all_eq = 0;
        if (bus.load_now) begin
            for (int i = 0; i < 4; i++) m_d[i] = tgt(i);
            m_cnt = 0;
            m_phase = -1;
        end else if (!bus.enable) begin
            m_cnt = 0;
            m_phase = -1;
        end else begin
            int tk;
            tk = (m_cnt == int'(bus.tick_div));
            if (m_phase >= 0) begin
                m_d[m_phase] = ramp(m_d[m_phase], tgt(m_phase), int'(bus.step));
                m_phase = m_phase == 3 ? -1 : m_phase + 1;
            end else if (tk != 0)
                m_phase = 0;
            m_cnt = tk != 0 ? 0 : (m_cnt + 1) % 65536;
        end
        m_set = all_eq;
    endtask

    task automatic compare_all();
        check("data_channel_0", int'(bus.data_channel_0), m_d[0]);
        check("data_channel_1", int'(bus.data_channel_1), m_d[1]);
        check("data_channel_2", int'(bus.data_channel_2), m_d[2]);
        check("data_channel_3", int'(bus.data_channel_3), m_d[3]);
        check("settled", int'(bus.settled), m_set);
    endtask

    task automatic cyc(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge pwm_clk);
            model_clk();
            @(negedge pwm_clk);
            compare_all();
        end
    endtask

    task automatic set_tgt(input int a, input int b, input int c, input int d);
        bus.target_channel_0 = 12'(a);
        bus.target_channel_1 = 12'(b);
        bus.target_channel_2 = 12'(c);
        bus.target_channel_3 = 12'(d);
    endtask

    task automatic pulse_load();
        bus.load_now = 1'b1;
        cyc();
        bus.load_now = 1'b0;
    endtask

    task automatic async_reset();
        rstn = 1'b0;
        #1;
        model_reset();
        compare_all();
        cyc(2);
        rstn = 1'b1;
        cyc();
    endtask

    task automatic wait_phase(input int p, input string tag);
        int k;
        k = 0;
        while (m_phase != p && k < 100) begin
            cyc();
            k++;
        end
        check(tag, int'(m_phase == p), 1);
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.load_now = 1'b0;
        bus.step = '0;
        bus.tick_div = '0;
        set_tgt(0, 0, 0, 0);
        #2;
        async_reset();

        // ramp channel 0 up in steps of 100, one update per 10 cycles
        bus.tick_div = 16'd9;
        bus.step = 12'd100;
        set_tgt(1000, 0, 0, 0);
        bus.enable = 1'b1;
        cyc(130);
        check("t1_d0_final", int'(bus.data_channel_0), 1000);
        check("t1_settled", int'(bus.settled), 1);

        // downward clamp without overshoot, then no underflow below 0
        bus.tick_div = 16'd4;
        set_tgt(1000, 4000, 0, 0);
        pulse_load();
        bus.target_channel_1 = 12'd3950;
        cyc(20);
        check("t2_clamp", int'(bus.data_channel_1), 3950);
        bus.target_channel_1 = 12'd50;
        pulse_load();
        bus.target_channel_1 = 12'd0;
        cyc(20);
        check("t2_no_underflow", int'(bus.data_channel_1), 0);

        // full-scale step reaches 4095 without wrapping
        bus.target_channel_2 = 12'd10;
        pulse_load();
        bus.step = 12'd4095;
        bus.target_channel_2 = 12'd4095;
        cyc(15);
        check("t3_top", int'(bus.data_channel_2), 4095);

        // back-to-back sweeps with tick_div=0
        set_tgt(0, 0, 0, 0);
        pulse_load();
        bus.tick_div = 16'd0;
        bus.step = 12'd40;
        set_tgt(40, 80, 120, 160);
        cyc(25);
        check("t4_d3", int'(bus.data_channel_3), 160);
        check("t4_settled", int'(bus.settled), 1);

        // direction reversal mid-ramp, then load_now overrides
        bus.tick_div = 16'd4;
        bus.step = 12'd100;
        bus.target_channel_2 = 12'd500;
        pulse_load();
        bus.target_channel_2 = 12'd2000;
        cyc(12);
        bus.target_channel_2 = 12'd300;
        cyc(120);
        check("t5_down", int'(bus.data_channel_2), 300);
        bus.target_channel_2 = 12'd3000;
        pulse_load();
        check("t5_load", int'(bus.data_channel_2), 3000);
        cyc(10);

        // reset asserted during the channel-2 update
        bus.tick_div = 16'd0;
        bus.step = 12'd1;
        set_tgt(4000, 4000, 4000, 4000);
        wait_phase(2, "t6_reach_upd2");
        async_reset();
        check("t6_rst_d2", int'(bus.data_channel_2), 0);

        // enable dropped mid-sweep freezes outputs
        wait_phase(1, "t6_reach_upd1");
        bus.enable = 1'b0;
        cyc(1000);
        check("t6_frozen_d2", int'(bus.data_channel_2), m_d[2]);
        bus.enable = 1'b1;

        // randomized traffic
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 599) == 0) async_reset();
            bus.enable = $urandom_range(0, 15) != 0;
            bus.load_now = $urandom_range(0, 40) == 0;
            if ($urandom_range(0, 30) == 0) bus.step = 12'($urandom_range(0, 4095) >> $urandom_range(0, 10));
            if ($urandom_range(0, 50) == 0) bus.tick_div = 16'($urandom_range(0, 7));
            if ($urandom_range(0, 20) == 0)
                set_tgt(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                        int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
            cyc();
        end
        bus.load_now = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
